// File: rtl/uart_rx.sv
// uart_rx -- 8N1 serial receiver with a first-word fall-through receive FIFO.
//
// Double-flops the asynchronous line and waits for a falling edge. It
// confirms the start bit at mid-period, then samples eight data bits LSB
// first. Each data bit is sampled one full bit period after the previous
// one. Well-formed bytes go into a DEPTH-entry FIFO. A low stop bit, or a
// byte that arrives while the FIFO is full, raises a sticky error flag.
//
// Build option: define UART_RX_MAJORITY_EN to replace the single mid-bit
// sample with a 2-of-3 vote over three consecutive synchronised samples.
//
// Ports:
//   clk_i        clock
//   rst_i        synchronous active-high reset
//   baud_div_i   clocks per bit (>= 4)
//   rx_en_i      receiver enable; low aborts any frame in progress
//   rx_bit_i     asynchronous serial line, idle high
//   rx_re_i      FIFO pop strobe (ignored while empty)
//   dout_o       FIFO head byte
//   full_o       FIFO full
//   empty_o      FIFO empty
//   frame_err_o  sticky: stop bit sampled low
//   overrun_o    sticky: byte dropped on a full FIFO
//   err_clr_i    clears both sticky flags (a same-cycle set wins)
module uart_rx #(
  parameter int DEPTH = 32
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic [15:0] baud_div_i,
  input  logic        rx_en_i,
  input  logic        rx_bit_i,
  input  logic        rx_re_i,
  output logic [7:0]  dout_o,
  output logic        full_o,
  output logic        empty_o,
  output logic        frame_err_o,
  output logic        overrun_o,
  input  logic        err_clr_i
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_START = 2'd1,
    ST_DATA  = 2'd2,
    ST_STOP  = 2'd3
  } state_t;

  logic          sync1_r;
  logic          rx_s_r;
  state_t        state_r;
  logic [15:0]   cnt_r;
  logic [2:0]    bit_idx_r;
  logic [7:0]    shift_r;
  logic [7:0]    mem_r [DEPTH];
  logic [AW:0]   wr_ptr_r;
  logic [AW:0]   rd_ptr_r;
  logic          frame_err_r;
  logic          overrun_r;

  logic          start_hit_s;
  logic          bit_hit_s;
  logic          sample_s;
  logic [15:0]   cnt_restart_s;
  logic          stop_event_s;
  logic          push_req_s;
  logic          ferr_set_s;
  logic          empty_s;
  logic          full_s;
  logic          pop_s;
  logic          push_ok_s;
  logic          drop_s;

  // Two-stage synchroniser on the raw line; both stages reset to idle-high.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync1_r <= 1'b1;
      rx_s_r  <= 1'b1;
    end else begin
      sync1_r <= rx_bit_i;
      rx_s_r  <= sync1_r;
    end
  end

`ifdef UART_RX_MAJORITY_EN
  // Holds rx_s from the two previous cycles so that the vote at target+1
  // can see the samples taken at target-1 and target.
  logic [1:0] hist_r;

  function automatic logic maj3(input logic a, input logic b, input logic c);
    maj3 = (a & b) | (a & c) | (b & c);
  endfunction

  // Shift register of past synchronised samples.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      hist_r <= 2'b11;
    end else begin
      hist_r <= {hist_r[0], rx_s_r};
    end
  end

  // The decision comes one cycle late, so the next bit starts its count at 1.
  always_comb begin
    start_hit_s   = (cnt_r == (baud_div_i >> 1));
    bit_hit_s     = (cnt_r == baud_div_i);
    sample_s      = maj3(hist_r[1], hist_r[0], rx_s_r);
    cnt_restart_s = 16'd1;
  end
`else
  // Single sample at the target count.
  always_comb begin
    start_hit_s   = (cnt_r == ((baud_div_i >> 1) - 16'd1));
    bit_hit_s     = (cnt_r == (baud_div_i - 16'd1));
    sample_s      = rx_s_r;
    cnt_restart_s = 16'd0;
  end
`endif

  // Stop-bit resolution and FIFO handshakes.
  always_comb begin
    stop_event_s = rx_en_i && (state_r == ST_STOP) && bit_hit_s;
    push_req_s   = stop_event_s && sample_s;
    ferr_set_s   = stop_event_s && !sample_s;
    empty_s      = (wr_ptr_r == rd_ptr_r);
    full_s       = (wr_ptr_r[AW] != rd_ptr_r[AW]) &&
                   (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    pop_s        = rx_re_i && !empty_s;
    // A full FIFO still takes a byte when a pop frees the slot in the same cycle.
    push_ok_s    = push_req_s && (!full_s || pop_s);
    drop_s       = push_req_s && full_s && !pop_s;
  end

  // Receive FSM: start-bit hunt, bit sampling and byte assembly.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
      shift_r   <= 8'h00;
    end else if (!rx_en_i) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 16'd0;
      bit_idx_r <= 3'd0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          cnt_r <= 16'd0;
          if (!rx_s_r) begin
            state_r <= ST_START;
          end
        end
        ST_START: begin
          if (start_hit_s) begin
            bit_idx_r <= 3'd0;
            if (!sample_s) begin
              state_r <= ST_DATA;
              cnt_r   <= cnt_restart_s;
            end else begin
              state_r <= ST_IDLE;
              cnt_r   <= 16'd0;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_DATA: begin
          if (bit_hit_s) begin
            shift_r[bit_idx_r] <= sample_s;
            bit_idx_r          <= bit_idx_r + 3'd1;
            cnt_r              <= cnt_restart_s;
            if (bit_idx_r == 3'd7) begin
              state_r <= ST_STOP;
            end
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        ST_STOP: begin
          if (bit_hit_s) begin
            state_r <= ST_IDLE;
            cnt_r   <= 16'd0;
          end else begin
            cnt_r <= cnt_r + 16'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          cnt_r   <= 16'd0;
        end
      endcase
    end
  end

  // FIFO storage; contents are don't-care until written, so no reset.
  always_ff @(posedge clk_i) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r[AW-1:0]] <= shift_r;
    end
  end

  // FIFO pointers and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_r    <= '0;
      rd_ptr_r    <= '0;
      frame_err_r <= 1'b0;
      overrun_r   <= 1'b0;
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + 1'b1;
      end
      if (pop_s) begin
        rd_ptr_r <= rd_ptr_r + 1'b1;
      end
      if (ferr_set_s) begin
        frame_err_r <= 1'b1;
      end else if (err_clr_i) begin
        frame_err_r <= 1'b0;
      end
      if (drop_s) begin
        overrun_r <= 1'b1;
      end else if (err_clr_i) begin
        overrun_r <= 1'b0;
      end
    end
  end

  assign dout_o      = mem_r[rd_ptr_r[AW-1:0]];
  assign empty_o     = empty_s;
  assign full_o      = full_s;
  assign frame_err_o = frame_err_r;
  assign overrun_o   = overrun_r;

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx (default build, single-sample mode).
// Frames are generated bit-by-bit as a transmitter would drive them. The
// outcome is predicted by a queue model: good frames are appended while
// there is room, a low stop bit sets the framing flag, and a frame that
// finds the FIFO full sets the overrun flag.
module tb_uart_rx;

  localparam int DEPTH = 32;

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_div;
  logic        rx_en;
  logic        rx_bit;
  logic        rx_re;
  logic        err_clr;
  logic [7:0]  dout;
  logic        full;
  logic        empty;
  logic        frame_err;
  logic        overrun;

  int n_pass  = 0;
  int n_total = 0;

  logic [7:0] model_q[$];
  logic       model_ferr;
  logic       model_ovr;

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         div;
    logic       exp_push;
  } vec_t;

  vec_t vecs[10];

  uart_rx #(.DEPTH(DEPTH)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .baud_div_i  (baud_div),
    .rx_en_i     (rx_en),
    .rx_bit_i    (rx_bit),
    .rx_re_i     (rx_re),
    .dout_o      (dout),
    .full_o      (full),
    .empty_o     (empty),
    .frame_err_o (frame_err),
    .overrun_o   (overrun),
    .err_clr_i   (err_clr)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    rx_bit = 1'b1;
    wait_cyc(n);
  endtask

  // Start bit, 8 data bits LSB first, then the stop bit. A bad stop bit is
  // held low for three quarters of a period, so it covers the mid-bit sample
  // but releases before a new start bit could be confirmed.
  task automatic send_frame(input logic [7:0] d, input logic stop, input int div);
    logic [8:0] f;
    f = {d, 1'b0};
    for (int i = 0; i < 9; i++) begin
      rx_bit = f[i];
      wait_cyc(div);
    end
    if (stop) begin
      rx_bit = 1'b1;
      wait_cyc(div);
    end else begin
      rx_bit = 1'b0;
      wait_cyc((3 * div) / 4);
      rx_bit = 1'b1;
      wait_cyc(div - (3 * div) / 4);
    end
  endtask

  task automatic model_frame(input logic [7:0] d, input logic stop);
    if (!stop) model_ferr = 1'b1;
    else if (model_q.size() < DEPTH) model_q.push_back(d);
    else model_ovr = 1'b1;
  endtask

  task automatic send_and_model(input logic [7:0] d, input logic stop, input int div);
    send_frame(d, stop, div);
    model_frame(d, stop);
  endtask

  task automatic check_state(input string tag);
    @(negedge clk);
    check({tag, "_empty"}, 32'(empty), 32'(model_q.size() == 0));
    check({tag, "_full"}, 32'(full), 32'(model_q.size() == DEPTH));
    check({tag, "_ferr"}, 32'(frame_err), 32'(model_ferr));
    check({tag, "_ovr"}, 32'(overrun), 32'(model_ovr));
    if (model_q.size() != 0) check({tag, "_dout"}, 32'(dout), 32'(model_q[0]));
  endtask

  task automatic pop_check(input string tag);
    @(negedge clk);
    check({tag, "_nonempty"}, 32'(empty), 32'(model_q.size() == 0));
    if (model_q.size() != 0) begin
      check({tag, "_pop"}, 32'(dout), 32'(model_q[0]));
      void'(model_q.pop_front());
    end
    rx_re = 1'b1;
    @(posedge clk);
    #1;
    rx_re = 1'b0;
  endtask

  task automatic clear_err();
    @(negedge clk);
    err_clr = 1'b1;
    @(posedge clk);
    #1;
    err_clr    = 1'b0;
    model_ferr = 1'b0;
    model_ovr  = 1'b0;
  endtask

  initial begin
    int c;
    rst = 1'b1; rx_en = 1'b1; rx_bit = 1'b1; rx_re = 1'b0; err_clr = 1'b0;
    baud_div = 16'd16;
    model_ferr = 1'b0; model_ovr = 1'b0;

    // Vector table: fixed corner cases followed by random frames.
    vecs[0] = '{8'h5A, 1'b1, 16, 1'b1};
    vecs[1] = '{8'hC3, 1'b0, 10, 1'b0};
    vecs[2] = '{8'h01, 1'b1, 7,  1'b1};
    vecs[3] = '{8'h80, 1'b1, 33, 1'b1};
    for (int i = 4; i < 10; i++) begin
      vecs[i].data     = 8'($urandom_range(0, 255));
      vecs[i].stop     = ($urandom_range(0, 3) != 0);
      vecs[i].div      = $urandom_range(10, 40);
      vecs[i].exp_push = vecs[i].stop;
    end

    wait_cyc(3);
    rst = 1'b0;
    check_state("reset");

    // Basic byte with a bounded wait on empty falling.
    baud_div = 16'd16;
    @(posedge clk); #1;
    c = 0;
    fork
      send_frame(8'hA5, 1'b1, 16);
      begin
        while (empty && c < 400) begin
          @(negedge clk);
          c++;
        end
      end
    join
    check("basic_latency_ok", 32'(c >= 148 && c <= 160), 32'd1);
    model_frame(8'hA5, 1'b1);
    idle(8);
    check_state("basic");
    pop_check("basic");

    // Back-to-back frames with no idle gap between them.
    send_and_model(8'h00, 1'b1, 16);
    send_and_model(8'hFF, 1'b1, 16);
    send_and_model(8'h55, 1'b1, 16);
    idle(16);
    check_state("b2b");
    for (int i = 0; i < 3; i++) pop_check("b2b");
    check_state("b2b_drained");

    // Glitch: a 3-cycle low pulse must not be taken as a start bit.
    rx_bit = 1'b0;
    wait_cyc(3);
    idle(40);
    check_state("glitch");
    send_and_model(8'h81, 1'b1, 16);
    idle(16);
    check_state("after_glitch");
    pop_check("after_glitch");

    // Framing error, then clear.
    send_and_model(8'h3C, 1'b0, 16);
    idle(32);
    check_state("frame_err");
    clear_err();
    check_state("frame_err_clr");

    // Table-driven frames at varied baud divisors.
    for (int i = 0; i < 10; i++) begin
      baud_div = 16'(vecs[i].div);
      idle(4);
      send_and_model(vecs[i].data, vecs[i].stop, vecs[i].div);
      idle(2 * vecs[i].div);
      @(negedge clk);
      check("vec_empty", 32'(empty), 32'(!vecs[i].exp_push));
      check("vec_ferr", 32'(frame_err), 32'(!vecs[i].exp_push));
      if (vecs[i].exp_push) begin
        check("vec_dout", 32'(dout), 32'(vecs[i].data));
        pop_check("vec");
      end else begin
        clear_err();
      end
    end
    check_state("vec_done");

    // Overrun: DEPTH+1 frames with no pops; the last one is lost.
    baud_div = 16'd16;
    idle(4);
    for (int i = 0; i <= DEPTH; i++) send_and_model(8'(i), 1'b1, 16);
    idle(16);
    check_state("overrun");
    for (int i = 0; i < DEPTH; i++) pop_check("overrun");
    check_state("overrun_drained");
    clear_err();
    check_state("overrun_clr");

    // Enable abort during data bit 4; trailing zero bits must not restart a frame.
    @(posedge clk); #1;
    fork
      send_frame(8'h0F, 1'b1, 16);
      begin
        wait_cyc(88);
        rx_en = 1'b0;
      end
    join
    idle(20);
    rx_en = 1'b1;
    idle(20);
    check_state("abort");

    // Reset with 3 bytes queued and the frame-error flag set.
    send_and_model(8'h11, 1'b1, 16);
    send_and_model(8'h22, 1'b1, 16);
    send_and_model(8'h33, 1'b1, 16);
    send_and_model(8'h44, 1'b0, 16);
    idle(16);
    check_state("pre_reset");
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    model_q.delete();
    model_ferr = 1'b0;
    model_ovr  = 1'b0;
    check_state("post_reset");

    // A pop on an empty FIFO is ignored.
    pop_check("empty_pop");
    check_state("empty_pop");

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
